// File: rtl/xor_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : xor_resp_checker
//  Description : Response checker for the XOR gate. Samples each applied
//                {din_a,din_b} pair with the observed dout, flags mismatches
//                against din_a ^ din_b, counts samples and errors
//                (saturating), tracks coverage of the four input
//                combinations and reports done/pass once all four are seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_resp_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             smp_valid,
  input  logic             din_a,
  input  logic             din_b,
  input  logic             dout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [3:0]       cov,
  output logic [1:0]       first_err_vec
);

  localparam logic [1:0]       c_st_idle  = 2'd0;
  localparam logic [1:0]       c_st_run   = 2'd1;
  localparam logic [1:0]       c_st_done  = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_one  = 1;
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_smp_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [3:0]       r_cov;
  logic [1:0]       r_first_err_vec;
  logic             r_err_flag;

  logic [1:0]       w_vec;
  logic             w_mismatch;
  logic [3:0]       w_cov_next;
  logic [CNT_W-1:0] w_smp_cnt_inc;
  logic [CNT_W-1:0] w_err_cnt_inc;

  // Decode the current sample: combination index, mismatch and saturating increments
  always_comb begin
    w_vec         = {din_a, din_b};
    w_mismatch    = (dout != (din_a ^ din_b));
    w_cov_next    = r_cov | (4'b0001 << w_vec);
    w_smp_cnt_inc = (r_smp_cnt == c_cnt_max) ? r_smp_cnt : r_smp_cnt + c_cnt_one;
    w_err_cnt_inc = (r_err_cnt == c_cnt_max) ? r_err_cnt : r_err_cnt + c_cnt_one;
  end

  // Control FSM plus result registers; start always wins over a same-cycle sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= c_st_idle;
      r_smp_cnt       <= '0;
      r_err_cnt       <= '0;
      r_cov           <= '0;
      r_first_err_vec <= '0;
      r_err_flag      <= 1'b0;
    end else begin
      r_err_flag <= 1'b0;
      if (start) begin
        // Restart from any state: results cleared, sample (if any) dropped
        r_state         <= c_st_run;
        r_smp_cnt       <= '0;
        r_err_cnt       <= '0;
        r_cov           <= '0;
        r_first_err_vec <= '0;
      end else if ((r_state == c_st_run) && smp_valid) begin
        r_smp_cnt <= w_smp_cnt_inc;
        r_cov     <= w_cov_next;
        if (w_mismatch) begin
          r_err_cnt  <= w_err_cnt_inc;
          r_err_flag <= 1'b1;
          // err_cnt saturates but never returns to zero, so zero means "first"
          if (r_err_cnt == '0) begin
            r_first_err_vec <= w_vec;
          end
        end
        if (w_cov_next == 4'b1111) begin
          r_state <= c_st_done;
        end
      end
    end
  end

  // Outputs come straight from registers; pass is qualified by DONE only
  assign busy          = (r_state == c_st_run);
  assign done          = (r_state == c_st_done);
  assign pass          = (r_state == c_st_done) && (r_err_cnt == '0);
  assign err_flag      = r_err_flag;
  assign err_cnt       = r_err_cnt;
  assign smp_cnt       = r_smp_cnt;
  assign cov           = r_cov;
  assign first_err_vec = r_first_err_vec;

endmodule
`default_nettype wire

// File: tb/tb_xor_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xor_resp_checker
//  Description : Self-checking bench for xor_resp_checker. Two instances
//                (CNT_W=8 and CNT_W=2) share stimulus; a behavioural model
//                with unbounded counts predicts both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, smp_valid, din_a, din_b, dout;

  logic       b8, d8, p8, f8;
  logic [7:0] e8, s8;
  logic [3:0] c8;
  logic [1:0] v8;
  logic       b2, d2, p2, f2;
  logic [1:0] e2, s2;
  logic [3:0] c2;
  logic [1:0] v2;

  xor_resp_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
    .din_a(din_a), .din_b(din_b), .dout(dout),
    .busy(b8), .done(d8), .pass(p8), .err_flag(f8),
    .err_cnt(e8), .smp_cnt(s8), .cov(c8), .first_err_vec(v8)
  );

  xor_resp_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
    .din_a(din_a), .din_b(din_b), .dout(dout),
    .busy(b2), .done(d2), .pass(p2), .err_flag(f2),
    .err_cnt(e2), .smp_cnt(s2), .cov(c2), .first_err_vec(v2)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int flag2_cnt = 0;

  // Behavioural model: phase 0=idle 1=run 2=done, counts unbounded
  int         m_phase, m_n, m_e;
  logic [3:0] m_cov;
  logic [1:0] m_fev;
  logic       m_flag;

  function automatic int sat(int n, int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_n = 0; m_e = 0; m_cov = 4'b0; m_fev = 2'b0; m_flag = 1'b0;
  endfunction

  function automatic void model_step(bit st, bit v, bit a, bit b, bit d);
    m_flag = 1'b0;
    if (st) begin
      m_phase = 1; m_n = 0; m_e = 0; m_cov = 4'b0; m_fev = 2'b0;
    end else if (m_phase == 1 && v) begin
      m_n++;
      m_cov[{a, b}] = 1'b1;
      if (d != (a ^ b)) begin
        if (m_e == 0) m_fev = {a, b};
        m_e++;
        m_flag = 1'b1;
      end
      if (m_cov == 4'b1111) m_phase = 2;
    end
  endfunction

  function automatic logic [31:0] exp_pack(int w);
    logic [7:0] ee = 8'(sat(m_e, w));
    logic [7:0] nn = 8'(sat(m_n, w));
    return {6'b0, (m_phase == 1), (m_phase == 2), (m_phase == 2 && m_e == 0),
            m_flag, ee, nn, m_cov, m_fev};
  endfunction

  function automatic logic [31:0] act8();
    return {6'b0, b8, d8, p8, f8, e8, s8, c8, v8};
  endfunction

  function automatic logic [31:0] act2();
    return {6'b0, b2, d2, p2, f2, 6'b0, e2, 6'b0, s2, c2, v2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs, let the edge happen, then check both DUTs
  task automatic step(input bit st, input bit v, input bit a, input bit b, input bit d);
    start = st; smp_valid = v; din_a = a; din_b = b; dout = d;
    @(posedge clk);
    #1;
    model_step(st, v, a, b, d);
    if (f2) flag2_cnt++;
    chk("model_w8", act8(), exp_pack(8));
    chk("model_w2", act2(), exp_pack(2));
  endtask

  typedef struct {
    bit st, v, a, b, d;
    bit e_busy, e_done, e_pass, e_flag;
    logic [7:0] e_smp, e_err;
    logic [3:0] e_cov;
    logic [1:0] e_fev;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rst_n = 1'b0; start = 0; smp_valid = 0; din_a = 0; din_b = 0; dout = 0;
    model_reset();

    // Happy path, then stuck-at-0 dout (second start is issued from DONE)
    tbl[0] = '{1,0,0,0,0, 1,0,0,0, 8'd0, 8'd0, 4'b0000, 2'b00};
    tbl[1] = '{0,1,0,0,0, 1,0,0,0, 8'd1, 8'd0, 4'b0001, 2'b00};
    tbl[2] = '{0,1,0,1,1, 1,0,0,0, 8'd2, 8'd0, 4'b0011, 2'b00};
    tbl[3] = '{0,1,1,0,1, 1,0,0,0, 8'd3, 8'd0, 4'b0111, 2'b00};
    tbl[4] = '{0,1,1,1,0, 0,1,1,0, 8'd4, 8'd0, 4'b1111, 2'b00};
    tbl[5] = '{1,0,0,0,0, 1,0,0,0, 8'd0, 8'd0, 4'b0000, 2'b00};
    tbl[6] = '{0,1,0,0,0, 1,0,0,0, 8'd1, 8'd0, 4'b0001, 2'b00};
    tbl[7] = '{0,1,0,1,0, 1,0,0,1, 8'd2, 8'd1, 4'b0011, 2'b01};
    tbl[8] = '{0,1,1,0,0, 1,0,0,1, 8'd3, 8'd2, 4'b0111, 2'b01};
    tbl[9] = '{0,1,1,1,0, 0,1,0,0, 8'd4, 8'd2, 4'b1111, 2'b01};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_w8", act8(), 32'h0);
    chk("reset_w2", act2(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 1, 0, 0);
    chk("idle_ignores_valid", act8(), 32'h0);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].st, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].d);
      chk($sformatf("tbl[%0d]", i), act8(),
          {6'b0, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_pass, tbl[i].e_flag,
           tbl[i].e_err, tbl[i].e_smp, tbl[i].e_cov, tbl[i].e_fev});
    end

    // Done holds and ignores samples
    step(0, 1, 0, 0, 1);
    chk("done_hold_smp", 32'(s8), 32'd4);

    // Repeats and gaps
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    step(0, 1, 1, 0, 1);
    chk("gap_not_done", 32'(d8), 32'd0);
    step(0, 1, 1, 1, 0);
    chk("gap_done", {29'b0, d8, p8, b8}, 32'b110);
    chk("gap_smp_cnt", 32'(s8), 32'd6);

    // Saturation with always-wrong dout
    step(1, 0, 0, 0, 0);
    flag2_cnt = 0;
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1);
    chk("sat_flag_pulses", 32'(flag2_cnt), 32'd8);
    chk("sat_cnts_w2", {28'b0, s2, e2}, 32'hF);
    chk("sat_pass_w2", {30'b0, d2, p2}, 32'b10);
    chk("sat_cnts_w8", {16'b0, s8, e8}, 32'h0808);

    // Restart in RUN coinciding with a valid sample
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    step(1, 1, 1, 0, 1);
    chk("restart_clear", {19'b0, b8, s8, c8}, {19'b0, 1'b1, 8'd0, 4'd0});

    // Reset mid-RUN, asserted between edges
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrun_reset_w8", act8(), 32'h0);
    chk("midrun_reset_w2", act2(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 1, 1, 1);
    chk("post_reset_ignore", act8(), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit st, v, a, b, d;
      st = ($urandom_range(0, 11) == 0);
      v  = ($urandom_range(0, 3) != 0);
      a  = 1'($urandom);
      b  = 1'($urandom);
      d  = (a ^ b) ^ ($urandom_range(0, 4) == 0);
      step(st, v, a, b, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xor_resp_checker.md
# xor_resp_checker

Synthesizable response checker for the XOR gate: the receive end of the stimulus/response interface that drives `din_a`/`din_b` into `xor_gate`. It samples each applied input pair together with the gate's observed `dout` and compares `dout` against `din_a ^ din_b`. It counts samples and mismatches, and tracks coverage of the four input combinations. It reports done/pass once all combinations have been observed. It sits beside `xor_gate` in on-chip self-test and is reused by benches as a scoreboard.

## Interface
- `CNT_W`, 8, width of the sample and error counters; both counters saturate at all-ones.
- `clk`  input  1  system clock; all state is updated on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle pulse; clears all results and enters RUN.
- `smp_valid`  input  1  when high in RUN, `din_a`, `din_b` and `dout` are sampled this edge.
- `din_a`  input  1  stimulus bit A, as applied to the gate.
- `din_b`  input  1  stimulus bit B, as applied to the gate.
- `dout`  input  1  observed gate output.
- `busy`  output  1  high in RUN.
- `done`  output  1  high in DONE.
- `pass`  output  1  high in DONE when `err_cnt == 0`; low otherwise.
- `err_flag`  output  1  one-cycle pulse, registered, for each mismatching sample.
- `err_cnt`  output  CNT_W  number of mismatching samples (saturating).
- `smp_cnt`  output  CNT_W  number of accepted samples (saturating).
- `cov`  output  4  bit `{din_a,din_b}` is set once that combination has been sampled.
- `first_err_vec`  output  2  `{din_a,din_b}` of the first mismatch since `start`; 2'b00 if there has been no mismatch.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `start` moves to RUN and clears the counters, `cov` and `first_err_vec`.
  - `smp_valid` is ignored.
- RUN, on a cycle with `smp_valid` high and `start` low:
  - `smp_cnt` increments unless already all-ones.
  - `cov[{din_a,din_b}]` is set to 1.
  - A mismatch is `dout != (din_a ^ din_b)`. On a mismatch, `err_cnt` increments unless already all-ones, and `err_flag` pulses.
  - On the first mismatch since `start`, `first_err_vec` captures `{din_a,din_b}`.
- RUN to DONE: when the updated `cov` equals 4'b1111. The completing sample is counted and checked in the same edge.
- DONE:
  - Results hold.
  - `smp_valid` is ignored.
  - `start` clears the results and returns to RUN.
- `start` while in RUN restarts: all results are cleared, the FSM stays in RUN, and any same-cycle `smp_valid` sample is dropped.
- Saturation applies only to the counts. A mismatch that arrives after `err_cnt` has saturated still pulses `err_flag`.
- `pass` is derived only in DONE. It is never high in IDLE or RUN.

## Timing
- Reset (async assert, sync release): FSM goes to IDLE. All outputs are 0: `busy`, `done`, `pass`, `err_flag`, `err_cnt`, `smp_cnt`, `cov`, `first_err_vec`.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `busy` goes high 1 cycle after the `start` edge.
- A sample taken at edge N appears in the counters, `cov` and `err_flag` after edge N. `err_flag` is high for exactly the one cycle after edge N.
- A completing sample at edge N: `done`/`pass` are high and `busy` is low after edge N, in the same cycle the final counts appear.
- Back-to-back samples are accepted every cycle. There is no backpressure.
- Reset asserted mid-RUN takes effect immediately. The partial results are discarded.

## Test plan
- Happy path: `start`, then samples 00/0, 01/1, 10/1, 11/0 (`{din_a,din_b}`/`dout`) on consecutive cycles.
  - Required: `done=1`, `pass=1`, `smp_cnt=4`, `err_cnt=0`, `cov=4'b1111`, `err_flag` never high.
- Stuck-at-0 `dout`, same four vectors.
  - Required: `err_flag` pulses after the 01 and 10 samples, `err_cnt=2`, `first_err_vec=2'b01`, `done=1`, `pass=0`.
- Repeats and gaps: 00 three times, `smp_valid` low for 2 cycles, then 01, 10, 11, all correct.
  - Required: `smp_cnt=6`, `done` asserted only after 11, `pass=1`.
- Saturation with `CNT_W=2` and always-wrong `dout`: five samples of 00, then 01, 10, 11.
  - Required: `smp_cnt=3`, `err_cnt=3`, `err_flag` pulses 8 times, `pass=0`.
- Restart: `start` in RUN after 2 correct samples, coinciding with a valid sample.
  - Required: counters are 0 next cycle, the same-cycle sample is dropped, and `busy` stays 1.
  - `start` in DONE returns to RUN with results cleared.
- Reset mid-RUN: drop `rst_n` after 2 samples.
  - Required: all outputs are 0 immediately, FSM is IDLE, and `smp_valid` is ignored until the next `start`.
